seq_fetch_exec_cpu: RTL and testbench

Parametrised multi-cycle accumulator CPU: fetches one instruction word per cycle-accurate memory handshake, executes it, and advances the instruction pointer. It extends the NOOP/HALT core with jumps, a conditional branch, accumulator arithmetic, illegal-opcode detection, a retired-instruction counter and synchronous reset. Memory handshaking is fully clocked, with no edge-triggered sampling of `mem_ready`. It sits between a testbench or memory emulator and the `stop_clock` control of the simulation harness.

---
 rtl/seq_fetch_exec_cpu_if.sv | 26 ++
 rtl/seq_fetch_exec_cpu.sv | 162 ++++++++++++++++
 tb/tb_seq_fetch_exec_cpu.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_fetch_exec_cpu_if.sv
// Instruction-fetch bus between the accumulator CPU and its memory.
// The CPU is the master: it raises mem_read with a stable mem_address and
// holds both until the memory answers with mem_ready and mem_value.
interface seq_fetch_exec_cpu_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_read;
  logic [DATA_WIDTH-1:0] mem_value;
  logic                  mem_ready;

  modport master (
    output mem_address,
    output mem_read,
    input  mem_value,
    input  mem_ready
  );

  modport slave (
    input  mem_address,
    input  mem_read,
    output mem_value,
    output mem_ready
  );
endinterface : seq_fetch_exec_cpu_if

// File: rtl/seq_fetch_exec_cpu.sv
// Multi-cycle accumulator CPU: ISSUE -> WAIT -> EXEC per instruction.
// Opcodes: NOOP, HALT, JUMP, LOADI, ADDI, JNZ; anything else halts with error.
// All outputs come straight from registers; EXEC results appear the cycle
// after the EXEC edge.
module seq_fetch_exec_cpu #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    OPCODE_WIDTH = 4,
  parameter int                    IP_STEP      = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_IP     = '0,
  parameter int                    CNT_WIDTH    = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  seq_fetch_exec_cpu_if.master        mem,
  output logic                        stop_clock,
  output logic                        error,
  output logic [DATA_WIDTH-1:0]       acc,
  output logic [ADDR_WIDTH-1:0]       ip,
  output logic [CNT_WIDTH-1:0]        retired
);

  localparam int OPERAND_WIDTH = DATA_WIDTH - OPCODE_WIDTH;
  // Operand is widened to the larger of the two widths, then cut to the
  // address width, so jump targets are zero-extended or truncated as needed.
  localparam int EXT_WIDTH = (OPERAND_WIDTH > ADDR_WIDTH) ? OPERAND_WIDTH : ADDR_WIDTH;

  localparam logic [OPCODE_WIDTH-1:0] OP_NOOP  = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_JUMP  = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_LOADI = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_JNZ   = OPCODE_WIDTH'(5);

  typedef enum logic [1:0] {
    ST_ISSUE,
    ST_WAIT,
    ST_EXEC,
    ST_HALTED
  } state_t;

  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   instr_q;
  logic [DATA_WIDTH-1:0]   acc_q;
  logic [ADDR_WIDTH-1:0]   ip_q;
  logic [CNT_WIDTH-1:0]    retired_q;
  logic                    mem_read_q;
  logic [ADDR_WIDTH-1:0]   mem_address_q;
  logic                    stop_q;
  logic                    error_q;

  // Decode of the latched instruction word and the candidate next values.
  logic [OPCODE_WIDTH-1:0]  opcode_d;
  logic [OPERAND_WIDTH-1:0] operand_d;
  logic [EXT_WIDTH-1:0]     operand_ext_d;
  logic [ADDR_WIDTH-1:0]    target_d;
  logic [ADDR_WIDTH-1:0]    ip_seq_d;
  logic [DATA_WIDTH-1:0]    imm_d;
  logic [DATA_WIDTH-1:0]    sum_d;
  logic [CNT_WIDTH-1:0]     retired_d;

  assign opcode_d      = instr_q[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign operand_d     = instr_q[OPERAND_WIDTH-1:0];
  assign operand_ext_d = EXT_WIDTH'(operand_d);
  assign target_d      = operand_ext_d[ADDR_WIDTH-1:0];
  assign ip_seq_d      = ip_q + ADDR_WIDTH'(IP_STEP);
  assign imm_d         = DATA_WIDTH'(operand_d);
  assign sum_d         = acc_q + imm_d;
  // Retired counter sticks at all-ones instead of wrapping.
  assign retired_d     = (&retired_q) ? retired_q : retired_q + CNT_WIDTH'(1);

  // Fetch/execute FSM; reset overrides every transition, including WAIT.
  always_ff @(posedge clock) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      state_q       <= ST_ISSUE;
      instr_q       <= '0;
      acc_q         <= '0;
      ip_q          <= RESET_IP;
      retired_q     <= '0;
      mem_read_q    <= 1'b0;
      mem_address_q <= RESET_IP;
      stop_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_ISSUE: begin
          mem_read_q    <= 1'b1;
          mem_address_q <= ip_q;
          state_q       <= ST_WAIT;
        end

        ST_WAIT: begin
          // Request stays up with a frozen address until the memory answers.
          if (mem.mem_ready) begin
            instr_q    <= mem.mem_value;
            mem_read_q <= 1'b0;
            state_q    <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          state_q <= ST_ISSUE;
          case (opcode_d)
            OP_NOOP: begin
              ip_q      <= ip_seq_d;
              retired_q <= retired_d;
            end
            OP_HALT: begin
              // ip keeps pointing at the HALT word.
              retired_q <= retired_d;
              stop_q    <= 1'b1;
              state_q   <= ST_HALTED;
            end
            OP_JUMP: begin
              ip_q      <= target_d;
              retired_q <= retired_d;
            end
            OP_LOADI: begin
              acc_q     <= imm_d;
              ip_q      <= ip_seq_d;
              retired_q <= retired_d;
            end
            OP_ADDI: begin
              acc_q     <= sum_d;
              ip_q      <= ip_seq_d;
              retired_q <= retired_d;
            end
            OP_JNZ: begin
              ip_q      <= (acc_q != '0) ? target_d : ip_seq_d;
              retired_q <= retired_d;
            end
            default: begin
              // Illegal opcode: halt in place, not counted as retired.
              stop_q  <= 1'b1;
              error_q <= 1'b1;
              state_q <= ST_HALTED;
            end
          endcase
        end

        ST_HALTED: begin
          state_q <= ST_HALTED;
        end

        default: begin
          state_q <= ST_ISSUE;
        end
      endcase
    end
  end

  assign mem.mem_read    = mem_read_q;
  assign mem.mem_address = mem_address_q;
  assign stop_clock      = stop_q;
  assign error           = error_q;
  assign acc             = acc_q;
  assign ip              = ip_q;
  assign retired         = retired_q;

endmodule : seq_fetch_exec_cpu

// File: tb/tb_seq_fetch_exec_cpu.sv
// Directed bench for seq_fetch_exec_cpu.
// DUT A: default parameters (32-bit data/address, 16-bit counter).
// DUT B: 40-bit data (36-bit operand, truncated jump targets), 2-bit counter.
module tb_seq_fetch_exec_cpu;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %-16s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ins(input logic [3:0] op, input logic [27:0] opd);
    return {op, opd};
  endfunction

  // ---------------- DUT A ----------------
  seq_fetch_exec_cpu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) a_if ();
  logic        stop_a, err_a;
  logic [31:0] acc_a, ip_a;
  logic [15:0] ret_a;

  seq_fetch_exec_cpu u_dut_a (
    .clock      (clk),
    .reset      (rst_a),
    .mem        (a_if.master),
    .stop_clock (stop_a),
    .error      (err_a),
    .acc        (acc_a),
    .ip         (ip_a),
    .retired    (ret_a)
  );

  logic [31:0] mem_a [0:63];
  int          delay_a = 0;
  logic        force_ready_a = 1'b0;
  int          rd_cnt_a = 0;

  always @(posedge clk) rd_cnt_a <= a_if.mem_read ? rd_cnt_a + 1 : 0;
  assign a_if.mem_ready = (a_if.mem_read && rd_cnt_a >= delay_a) || force_ready_a;
  assign a_if.mem_value = mem_a[a_if.mem_address[6:1]];

  // Fetch monitor: address must not move while a request is outstanding.
  logic        prev_rd_a = 1'b0;
  logic [31:0] held_addr_a = '0;
  int          unstable_a = 0;
  int          rd_cycles_a = 0;
  always @(negedge clk) begin
    if (a_if.mem_read) begin
      rd_cycles_a++;
      if (prev_rd_a && a_if.mem_address != held_addr_a) unstable_a++;
      held_addr_a = a_if.mem_address;
    end
    prev_rd_a = a_if.mem_read;
  end

  // ---------------- DUT B ----------------
  seq_fetch_exec_cpu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(40)) b_if ();
  logic        stop_b, err_b;
  logic [39:0] acc_b;
  logic [31:0] ip_b;
  logic [1:0]  ret_b;

  seq_fetch_exec_cpu #(.DATA_WIDTH(40), .CNT_WIDTH(2)) u_dut_b (
    .clock      (clk),
    .reset      (rst_b),
    .mem        (b_if.master),
    .stop_clock (stop_b),
    .error      (err_b),
    .acc        (acc_b),
    .ip         (ip_b),
    .retired    (ret_b)
  );

  logic [39:0] mem_b [0:3];
  int          rd_cnt_b = 0;
  always @(posedge clk) rd_cnt_b <= b_if.mem_read ? rd_cnt_b + 1 : 0;
  assign b_if.mem_ready = b_if.mem_read && rd_cnt_b >= 1;
  assign b_if.mem_value = (b_if.mem_address == 32'hFFFF_FFFE) ? 40'h0 : mem_b[b_if.mem_address[2:1]];

  logic        prev_rd_b = 1'b0;
  logic [31:0] fetch_q_b [$];
  always @(negedge clk) begin
    if (b_if.mem_read && !prev_rd_b) fetch_q_b.push_back(b_if.mem_address);
    prev_rd_b = b_if.mem_read;
  end

  // ---------------- helpers ----------------
  task automatic fill_halt_a();
    for (int i = 0; i < 64; i++) mem_a[i] = ins(4'h1, 28'h0);
  endtask

  task automatic restart_a();
    rst_a = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
  endtask

  // Counts edges after reset release until stop_clock, bounded by budget.
  task automatic wait_stop_a(input int budget, output int edges);
    edges = 0;
    while (!stop_a && edges < budget) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  int edges;
  int rd_snap;
  int n;
  logic [31:0] exp_fetch [6];

  initial begin
    fill_halt_a();
    mem_b[0] = {4'h5, 36'h6};              // 0: JNZ 6
    mem_b[1] = {4'h3, 36'h1};              // 2: LOADI 1
    mem_b[2] = {4'h2, 36'h1_FFFF_FFFE};    // 4: JUMP, truncated to 0xFFFFFFFE
    mem_b[3] = {4'h1, 36'h0};              // 6: HALT

    // ---- reset state ----
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_mem_read", a_if.mem_read, 0);
    check("rst_mem_addr", a_if.mem_address, 0);
    check("rst_stop", stop_a, 0);
    check("rst_error", err_a, 0);
    check("rst_acc", acc_a, 0);
    check("rst_ip", ip_a, 0);
    check("rst_retired", ret_a, 0);
    check("rstB_retired", ret_b, 0);

    // ---- T1: NOOPs at 0..16, HALT at 18, zero wait ----
    fill_halt_a();
    for (int i = 0; i <= 8; i++) mem_a[i] = ins(4'h0, 28'h0);
    delay_a = 0;
    restart_a();
    @(posedge clk);
    #1;
    check("t1_read_rise", a_if.mem_read, 1);
    check("t1_first_addr", a_if.mem_address, 0);
    wait_stop_a(200, edges);
    edges++;
    check("t1_stop", stop_a, 1);
    check("t1_edges", edges, 30);
    check("t1_ip", ip_a, 18);
    check("t1_retired", ret_a, 10);
    check("t1_error", err_a, 0);

    // ---- T2: LOADI 3; ADDI 0x0FFFFFFF; HALT ----
    fill_halt_a();
    mem_a[0] = ins(4'h3, 28'h3);
    mem_a[1] = ins(4'h4, 28'hFFF_FFFF);
    restart_a();
    wait_stop_a(200, edges);
    check("t2_stop", stop_a, 1);
    check("t2_acc", acc_a, 32'h1000_0002);
    check("t2_ip", ip_a, 4);
    check("t2_retired", ret_a, 3);

    // ---- T3: countdown loop with 2-cycle ready delay ----
    // acc = 0x10000000, each pass adds 0x10000000; reaches 0 after 15 passes.
    fill_halt_a();
    mem_a[0] = ins(4'h3, 28'h3);           // LOADI 3
    mem_a[1] = ins(4'h4, 28'hFFF_FFFD);    // ADDI -> 0x10000000
    mem_a[2] = ins(4'h4, 28'hFFF_FFFF);    // 4: ADDI all-ones
    mem_a[3] = ins(4'h4, 28'h1);           // 6: ADDI 1
    mem_a[4] = ins(4'h5, 28'h4);           // 8: JNZ 4
    delay_a = 2;
    restart_a();
    unstable_a = 0;
    wait_stop_a(2000, edges);
    check("t3_stop", stop_a, 1);
    check("t3_acc", acc_a, 0);
    check("t3_ip", ip_a, 10);
    check("t3_retired", ret_a, 48);
    check("t3_edges", edges, 240);
    check("t3_addr_stable", unstable_a, 0);
    check("t3_error", err_a, 0);

    // ---- T4: opcode 7 at address 4 ----
    fill_halt_a();
    mem_a[0] = ins(4'h3, 28'h5);
    mem_a[1] = ins(4'h0, 28'h0);
    mem_a[2] = ins(4'h7, 28'h0);
    delay_a = 0;
    restart_a();
    wait_stop_a(200, edges);
    check("t4_stop", stop_a, 1);
    check("t4_error", err_a, 1);
    check("t4_ip", ip_a, 4);
    check("t4_retired", ret_a, 2);
    check("t4_acc", acc_a, 5);
    rd_snap = rd_cycles_a;
    repeat (10) @(posedge clk);
    #1;
    check("t4_no_read", rd_cycles_a, rd_snap);
    check("t4_stop_held", stop_a, 1);

    // ---- T4b: lowest illegal opcode 6 ----
    fill_halt_a();
    mem_a[0] = ins(4'h4, 28'h1);
    mem_a[1] = ins(4'h6, 28'h0);
    restart_a();
    wait_stop_a(200, edges);
    check("t4b_error", err_a, 1);
    check("t4b_ip", ip_a, 2);
    check("t4b_retired", ret_a, 1);
    check("t4b_acc", acc_a, 1);

    // ---- T5: reset during WAIT at address 6 ----
    fill_halt_a();
    mem_a[0] = ins(4'h0, 28'h0);
    mem_a[1] = ins(4'h0, 28'h0);
    mem_a[2] = ins(4'h3, 28'h9);
    mem_a[3] = ins(4'h3, 28'h77);
    delay_a = 3;
    restart_a();
    n = 0;
    while (!(a_if.mem_read && a_if.mem_address == 32'd6) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t5_reach6", a_if.mem_address, 6);
    check("t5_acc_pre", acc_a, 9);
    rst_a = 1'b1;
    force_ready_a = 1'b1;
    @(posedge clk);
    #1;
    check("t5_read_drop", a_if.mem_read, 0);
    check("t5_ip", ip_a, 0);
    check("t5_addr", a_if.mem_address, 0);
    check("t5_acc", acc_a, 0);
    check("t5_retired", ret_a, 0);
    @(negedge clk);
    force_ready_a = 1'b0;
    rst_a = 1'b0;
    @(posedge clk);
    #1;
    check("t5_refetch_rd", a_if.mem_read, 1);
    check("t5_refetch_adr", a_if.mem_address, 0);
    wait_stop_a(400, edges);
    check("t5_stop", stop_a, 1);
    check("t5_final_acc", acc_a, 32'h77);
    check("t5_final_ret", ret_a, 5);
    check("t5_final_ip", ip_a, 8);

    // ---- T6: DUT B, truncated jump, ip wrap, counter saturation ----
    @(negedge clk);
    rst_b = 1'b0;
    n = 0;
    while (!stop_b && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    exp_fetch = '{32'h0, 32'h2, 32'h4, 32'hFFFF_FFFE, 32'h0, 32'h6};
    check("t6_stop", stop_b, 1);
    check("t6_fetch_count", fetch_q_b.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < fetch_q_b.size()) check($sformatf("t6_fetch%0d", i), fetch_q_b[i], exp_fetch[i]);
      else check($sformatf("t6_fetch%0d", i), 64'hDEAD, exp_fetch[i]);
    end
    check("t6_ip", ip_b, 6);
    check("t6_retired_sat", ret_b, 3);
    check("t6_acc", acc_b, 1);
    check("t6_error", err_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_seq_fetch_exec_cpu
